// File: rtl/pixel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_pkg
// Description : Shared types and helpers for the pixel array sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_pkg;

    localparam int c_MAX_ADC_BITS = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ERASE     = 3'd1,
        ST_EXPOSE    = 3'd2,
        ST_CONVERT   = 3'd3,
        ST_ROW_LATCH = 3'd4,
        ST_ROW_SHIFT = 3'd5,
        ST_DONE      = 3'd6
    } pixel_seq_state_t;

    // Index width for n items, never narrower than one bit
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [c_MAX_ADC_BITS-1:0] bin2gray(input logic [c_MAX_ADC_BITS-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_gray_counter.sv
`default_nettype none
// ============================================================================
// Module      : pixel_gray_counter
// Description : Binary ramp counter with registered Gray-coded output.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_gray_counter
    import pixel_pkg::*;
#(
    parameter int ADC_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clear,
    input  logic                i_enable,
    output logic [ADC_BITS-1:0] o_gray,
    output logic                o_last
);

    localparam logic [ADC_BITS-1:0] c_GRAY_LAST =
        ADC_BITS'(bin2gray(c_MAX_ADC_BITS'({ADC_BITS{1'b1}})));

    logic [ADC_BITS-1:0] r_bin;

    // Gray output lags the binary count by one step so the first enabled cycle shows 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin  <= '0;
            o_gray <= '0;
        end else if (i_clear) begin
            r_bin  <= '0;
            o_gray <= '0;
        end else if (i_enable) begin
            o_gray <= ADC_BITS'(bin2gray(c_MAX_ADC_BITS'(r_bin)));
            r_bin  <= r_bin + ADC_BITS'(1);
        end
    end

    assign o_last = (o_gray == c_GRAY_LAST);

endmodule
`default_nettype wire

// File: rtl/pixel_array_seq.sv
`default_nettype none
// ============================================================================
// Module      : pixel_array_seq
// Description : Erase/expose/convert sequencer with row-by-row pixel streaming.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_array_seq
    import pixel_pkg::*;
#(
    parameter int N_ROWS       = 2,
    parameter int N_COLS       = 2,
    parameter int ADC_BITS     = 8,
    parameter int ERASE_CYCLES = 5,
    parameter int EXP_W        = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             continuous,
    input  logic                             stop,
    input  logic [EXP_W-1:0]                 expose_cycles,
    input  logic [N_COLS*ADC_BITS-1:0]       pixel_data,
    output logic                             erase,
    output logic                             expose,
    output logic                             convert,
    output logic [ADC_BITS-1:0]              adc_count,
    output logic                             read_en,
    output logic [clog2_min1(N_ROWS)-1:0]    row_sel,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ADC_BITS-1:0]              out_data,
    output logic [clog2_min1(N_ROWS)-1:0]    out_row,
    output logic [clog2_min1(N_COLS)-1:0]    out_col,
    output logic                             busy,
    output logic                             frame_done
);

    localparam int c_ROW_W = clog2_min1(N_ROWS);
    localparam int c_COL_W = clog2_min1(N_COLS);
    localparam int c_ERS_W = clog2_min1(ERASE_CYCLES);
    localparam int c_CNT_W = (EXP_W > c_ERS_W) ? EXP_W : c_ERS_W;
    localparam logic [c_ROW_W-1:0] c_ROW_LAST   = c_ROW_W'(N_ROWS - 1);
    localparam logic [c_COL_W-1:0] c_COL_LAST   = c_COL_W'(N_COLS - 1);
    localparam logic [c_CNT_W-1:0] c_ERASE_LAST = c_CNT_W'(ERASE_CYCLES - 1);

    pixel_seq_state_t              r_state;
    pixel_seq_state_t              w_next;
    logic [c_CNT_W-1:0]            r_cnt;
    logic [EXP_W-1:0]              r_exp;
    logic [EXP_W-1:0]              w_exp_in;
    logic                          r_cont;
    logic [c_ROW_W-1:0]            r_row;
    logic [c_ROW_W-1:0]            w_row_nx;
    logic [c_COL_W-1:0]            r_col;
    logic [c_COL_W-1:0]            w_col_nx;
    logic [N_COLS-1:0][ADC_BITS-1:0] r_buf;
    logic                          w_adc_last;

    assign w_exp_in = (expose_cycles == '0) ? EXP_W'(1) : expose_cycles;

    always_comb begin
        w_next   = r_state;
        w_row_nx = r_row;
        w_col_nx = r_col;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_ERASE;
            ST_ERASE:  if (r_cnt == c_ERASE_LAST) w_next = ST_EXPOSE;
            ST_EXPOSE: if (r_cnt == c_CNT_W'(r_exp) - c_CNT_W'(1)) w_next = ST_CONVERT;
            ST_CONVERT: begin
                w_row_nx = '0;
                w_col_nx = '0;
                if (w_adc_last) w_next = ST_ROW_LATCH;
            end
            ST_ROW_LATCH: begin
                w_col_nx = '0;
                w_next   = ST_ROW_SHIFT;
            end
            ST_ROW_SHIFT: begin
                if (out_ready) begin
                    if (r_col == c_COL_LAST) begin
                        w_col_nx = '0;
                        if (r_row == c_ROW_LAST) begin
                            w_row_nx = '0;
                            w_next   = ST_DONE;
                        end else begin
                            w_row_nx = r_row + c_ROW_W'(1);
                            w_next   = ST_ROW_LATCH;
                        end
                    end else begin
                        w_col_nx = r_col + c_COL_W'(1);
                    end
                end
            end
            ST_DONE:   w_next = (r_cont && !stop) ? ST_ERASE : ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Driven from the next state so the Gray value tracks the ramp with no lag
    pixel_gray_counter #(
        .ADC_BITS (ADC_BITS)
    ) u_gray (
        .clk      (clk),
        .rst      (reset),
        .i_clear  (w_next != ST_CONVERT),
        .i_enable (w_next == ST_CONVERT),
        .o_gray   (adc_count),
        .o_last   (w_adc_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_exp      <= '0;
            r_cont     <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
            r_buf      <= '0;
            erase      <= 1'b0;
            expose     <= 1'b0;
            convert    <= 1'b0;
            read_en    <= 1'b0;
            row_sel    <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_row    <= '0;
            out_col    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            r_state <= w_next;
            r_row   <= w_row_nx;
            r_col   <= w_col_nx;

            if (w_next != r_state)
                r_cnt <= '0;
            else if (r_state == ST_ERASE || r_state == ST_EXPOSE)
                r_cnt <= r_cnt + c_CNT_W'(1);

            if ((r_state == ST_IDLE && start) || (r_state == ST_DONE && w_next == ST_ERASE))
                r_exp <= w_exp_in;

            if (stop)
                r_cont <= 1'b0;
            else if (r_state == ST_IDLE && start)
                r_cont <= continuous;

            if (r_state == ST_ROW_LATCH)
                r_buf <= pixel_data;

            erase      <= (w_next == ST_ERASE);
            expose     <= (w_next == ST_EXPOSE);
            convert    <= (w_next == ST_CONVERT);
            read_en    <= (w_next == ST_ROW_LATCH);
            row_sel    <= (w_next == ST_ROW_LATCH) ? w_row_nx : '0;
            out_valid  <= (w_next == ST_ROW_SHIFT);
            frame_done <= (w_next == ST_DONE);
            busy       <= (w_next != ST_IDLE);

            // Column 0 bypasses the buffer since it is captured on the same edge
            if (w_next == ST_ROW_SHIFT) begin
                out_data <= (r_state == ST_ROW_LATCH) ? pixel_data[ADC_BITS-1:0] : r_buf[w_col_nx];
                out_row  <= w_row_nx;
                out_col  <= w_col_nx;
            end else begin
                out_data <= '0;
                out_row  <= '0;
                out_col  <= '0;
            end
        end
    end

endmodule
`default_nettype wire
